// File: rtl/pipe_skid_reg.sv
// Two-entry in-order skid buffer: a main register drives out_data and a skid
// register catches the one extra beat that arrives while the output is stalled.
module pipe_skid_reg #(
  parameter int unsigned     N        = 32,
  parameter logic [N-1:0]    RST_DATA = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         in_xfer, out_xfer;

  // Handshake outputs come from registered state only, so no ready/valid
  // combinational path crosses the block.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_DATA;
      skid_d  = RST_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain path can fire.
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RST_DATA;
          skid_d  = RST_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_DATA;
      skid_q  <= RST_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus hand sequences for reset/flush corners and a
// queue-model random phase for ordering and occupancy.
module tb_pipe_skid_reg;
  localparam int unsigned  N  = 32;
  localparam logic [N-1:0] RD = 32'h0BAD_F00D;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic         fl;
    logic         iv;
    logic [N-1:0] id;
    logic         ordy;
    logic         eir;
    logic         eov;
    logic [N-1:0] eod;
    logic [1:0]   eocc;
  } vec_t;

  vec_t        vecs[$];
  logic [N-1:0] model_q[$];

  pipe_skid_reg #(.N(N), .RST_DATA(RD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eir, input logic eov,
                         input logic [N-1:0] eod, input logic [1:0] eocc);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, eir});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
    chk({tag, ".out_data"},  out_data,           eod);
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, eocc});
  endtask

  task automatic add(input logic fl, input logic iv, input logic [N-1:0] id, input logic ordy,
                     input logic eir, input logic eov, input logic [N-1:0] eod, input logic [1:0] eocc);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.eod = eod; v.eocc = eocc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [N-1:0] id, input logic ordy);
    flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  initial begin
    // Expected values are the outputs just after the edge the vector is applied on.
    // Streaming at full rate: one-cycle latency, occupancy stays 1.
    add(F, T, 32'h1, T,  T, T, 32'h1, 2'd1);
    add(F, T, 32'h2, T,  T, T, 32'h2, 2'd1);
    add(F, T, 32'h3, T,  T, T, 32'h3, 2'd1);
    add(F, F, 32'h0, T,  T, F, 32'h3, 2'd0);
    // Backpressure fills the skid; third offer is ignored.
    add(F, T, 32'hA, F,  T, T, 32'hA, 2'd1);
    add(F, T, 32'hB, F,  F, T, 32'hA, 2'd2);
    add(F, T, 32'hC, F,  F, T, 32'hA, 2'd2);
    add(F, T, 32'hC, T,  T, T, 32'hB, 2'd1);
    add(F, F, 32'h0, T,  T, F, 32'hB, 2'd0);
    // Simultaneous in/out in ONE replaces main.
    add(F, T, 32'h5, F,  T, T, 32'h5, 2'd1);
    add(F, T, 32'h7, T,  T, T, 32'h7, 2'd1);
    // Flush from TWO with a concurrent offer.
    add(F, T, 32'h8, F,  F, T, 32'h7, 2'd2);
    add(T, T, 32'hD, T,  T, F, RD,    2'd0);
    add(F, F, 32'h0, T,  T, F, RD,    2'd0);
    // Flush in EMPTY discards the offer; flush in ONE with out_ready.
    add(T, T, 32'h9, T,  T, F, RD,    2'd0);
    add(F, T, 32'h4, F,  T, T, 32'h4, 2'd1);
    add(T, F, 32'h0, T,  T, F, RD,    2'd0);

    rst = 1'b1;
    drive(F, F, '0, F);
    #2;
    chk_all("reset", T, F, RD, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].eir, vecs[i].eov, vecs[i].eod, vecs[i].eocc);
      @(negedge clk);
    end

    // Async reset between edges while holding 0x5 in ONE.
    drive(F, T, 32'h5, F);
    @(posedge clk);
    #1;
    chk_all("pre_rst", T, T, 32'h5, 2'd1);
    @(negedge clk);
    drive(F, T, 32'h6, F);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_async", T, F, RD, 2'd0);
    @(posedge clk);
    #1;
    chk_all("rst_held", T, F, RD, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(F, T, 32'h6, T);
    @(posedge clk);
    #1;
    chk_all("post_rst", T, T, 32'h6, 2'd1);
    @(negedge clk);
    drive(F, F, '0, T);
    @(posedge clk);
    #1;
    chk_all("post_rst_drain", T, F, 32'h6, 2'd0);

    // Random traffic against a queue model.
    for (int c = 0; c < 10000; c++) begin
      logic iv, ordy, ixf, oxf;
      logic [N-1:0] d;
      @(negedge clk);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      d    = $urandom();
      drive(F, iv, d, ordy);
      #1;
      chk("rnd.in_ready",  {31'd0, in_ready},  {31'd0, (model_q.size() < 2)});
      chk("rnd.out_valid", {31'd0, out_valid}, {31'd0, (model_q.size() > 0)});
      chk("rnd.occupancy", {30'd0, occupancy}, 32'(model_q.size()));
      if (model_q.size() > 0) chk("rnd.out_data", out_data, model_q[0]);
      ixf = iv && (model_q.size() < 2);
      oxf = ordy && (model_q.size() > 0);
      @(posedge clk);
      if (oxf) void'(model_q.pop_front());
      if (ixf) model_q.push_back(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
